// File: rtl/ysyx_22050550_seq_ctrl_pkg.sv
// Shared encodings for the ysyx_22050550 multi-cycle sequencer: FSM states,
// special instruction encodings, memory opcodes and the default reset PC.
package ysyx_22050550_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
  localparam logic [6:0]  OPC_STORE    = 7'b0100011;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

  // States in which the core is blocked on an external handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH_REQ) || (s == S_FETCH_WAIT) ||
           (s == S_MEM_REQ)   || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_22050550_wait_timer.sv
// Wait-state watchdog: counts cycles spent in the current wait state and
// flags the cycle in which the TIMEOUT-th consecutive wait cycle elapses.
module ysyx_22050550_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_cur;

  // clr marks the first cycle of a freshly entered state, so that cycle counts as zero.
  assign cnt_cur = clr ? '0 : cnt;
  assign expired = en && (cnt_cur == LAST);

  always_ff @(posedge clk) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= cnt_cur + 1'b1;
    else         cnt <= cnt_cur;
  end

endmodule

// File: rtl/ysyx_22050550_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC/IR, runs fetch and load/store
// handshakes, gates regfile writeback, halts on ebreak, traps on timeout.
module ysyx_22050550_seq_ctrl
  import ysyx_22050550_seq_ctrl_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter int              TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid_o,
  output logic [PC_W-1:0]   ifu_req_addr_o,
  input  logic              ifu_req_ready_i,
  input  logic              ifu_resp_valid_i,
  input  logic [INST_W-1:0] ifu_resp_data_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] instr_o,
  input  logic              id_rden_i,
  input  logic [PC_W-1:0]   exu_next_pc_i,
  output logic              lsu_req_valid_o,
  input  logic              lsu_req_ready_i,
  input  logic              lsu_resp_valid_i,
  output logic              rf_we_o,
  output logic              halt_o,
  output logic              trap_o,
  output logic [63:0]       instret_o
);

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     npc;
  logic [INST_W-1:0]   instr;
  logic [63:0]         instret;
  logic                ifu_vld;
  logic                lsu_vld;
  logic                rf_we;
  logic                halt;
  logic                trap;
  logic                tmr_clr;
  logic                tmr_exp;
  logic                wb_en;

  ysyx_22050550_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (is_wait_state(state)),
    .expired (tmr_exp)
  );

  // IDU is combinational and instr is frozen from DECODE on, so the
  // writeback enable can be evaluated the cycle before WB.
  assign wb_en = id_rden_i && (instr[11:7] != 5'd0) && (instr[6:0] != OPC_STORE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_FETCH_REQ;
      pc      <= RESET_PC;
      npc     <= RESET_PC;
      instr   <= INST_W'(INST_NOP);
      instret <= '0;
      ifu_vld <= 1'b1;
      lsu_vld <= 1'b0;
      rf_we   <= 1'b0;
      halt    <= 1'b0;
      trap    <= 1'b0;
      tmr_clr <= 1'b1;
    end else begin
      rf_we   <= 1'b0;
      tmr_clr <= 1'b0;
      case (state)
        S_FETCH_REQ: begin
          if (ifu_req_ready_i) begin
            state   <= S_FETCH_WAIT;
            ifu_vld <= 1'b0;
            tmr_clr <= 1'b1;
          end else if (tmr_exp) begin
            state   <= S_HALT;
            ifu_vld <= 1'b0;
            halt    <= 1'b1;
            trap    <= 1'b1;
          end
        end
        S_FETCH_WAIT: begin
          if (ifu_resp_valid_i) begin
            state <= S_DECODE;
            instr <= ifu_resp_data_i;
          end else if (tmr_exp) begin
            state <= S_HALT;
            halt  <= 1'b1;
            trap  <= 1'b1;
          end
        end
        S_DECODE: begin
          if (instr == INST_W'(INST_EBREAK)) begin
            state <= S_HALT;
            halt  <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          npc <= exu_next_pc_i;
          if (is_mem_op(instr[6:0])) begin
            state   <= S_MEM_REQ;
            lsu_vld <= 1'b1;
            tmr_clr <= 1'b1;
          end else begin
            state <= S_WB;
            rf_we <= wb_en;
          end
        end
        S_MEM_REQ: begin
          if (lsu_req_ready_i) begin
            state   <= S_MEM_WAIT;
            lsu_vld <= 1'b0;
            tmr_clr <= 1'b1;
          end else if (tmr_exp) begin
            state   <= S_HALT;
            lsu_vld <= 1'b0;
            halt    <= 1'b1;
            trap    <= 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (lsu_resp_valid_i) begin
            state <= S_WB;
            rf_we <= wb_en;
          end else if (tmr_exp) begin
            state <= S_HALT;
            halt  <= 1'b1;
            trap  <= 1'b1;
          end
        end
        S_WB: begin
          pc      <= npc;
          instret <= instret + 64'd1;
          state   <= S_FETCH_REQ;
          ifu_vld <= 1'b1;
          tmr_clr <= 1'b1;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
          halt  <= 1'b1;
        end
      endcase
    end
  end

  assign ifu_req_valid_o = ifu_vld;
  assign ifu_req_addr_o  = pc;
  assign pc_o            = pc;
  assign instr_o         = instr;
  assign lsu_req_valid_o = lsu_vld;
  assign rf_we_o         = rf_we;
  assign halt_o          = halt;
  assign trap_o          = trap;
  assign instret_o       = instret;

endmodule
